// File: rtl/tempsense_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tempsense_pkg                                                    |
// | Brief   : Shared state encoding, mode codes and DAC range helpers for the  |
// |           tempsense measurement controller.                                |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package tempsense_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRECHARGE  = 3'd1,
    ST_TRANSITION = 3'd2,
    ST_MEASURE    = 3'd3,
    ST_EVALUATE   = 3'd4,
    ST_ACCUM      = 3'd5,
    ST_DONE       = 3'd6
  } state_t;

  localparam logic MODE_SWEEP = 1'b0;
  localparam logic MODE_SAR   = 1'b1;

  localparam int VMIN = 0;

  function automatic int vmax(input int n_vdac);
    return (1 << n_vdac) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tempsense_meas_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tempsense_meas_ctrl_if                                           |
// | Brief   : Control/sensor bundle between the measurement controller        |
// |           (master) and its environment (slave).                            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface tempsense_meas_ctrl_if #(
  parameter int N_VDAC = 6
);
  logic              i_start;
  logic              i_continuous;
  logic              i_mode;
  logic              i_tempdelay;
  logic [N_VDAC-1:0] o_dac_data;
  logic              o_dac_en;
  logic              o_precharge_n;
  logic [N_VDAC-1:0] o_result;
  logic              o_valid;
  logic              o_busy;
  logic              o_sat_lo;
  logic              o_sat_hi;

  modport master (
    input  i_start, i_continuous, i_mode, i_tempdelay,
    output o_dac_data, o_dac_en, o_precharge_n, o_result, o_valid, o_busy,
           o_sat_lo, o_sat_hi
  );

  modport slave (
    output i_start, i_continuous, i_mode, i_tempdelay,
    input  o_dac_data, o_dac_en, o_precharge_n, o_result, o_valid, o_busy,
           o_sat_lo, o_sat_hi
  );
endinterface
`default_nettype wire

// File: rtl/tempsense_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tempsense_sync                                                   |
// | Brief   : Flop chain bringing the asynchronous sensor delay output into    |
// |           the clk domain.                                                  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tempsense_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic [SYNC_STAGES-1:0] r_chain;

  generate
    if (SYNC_STAGES == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (reset) r_chain[0] <= 1'b0;
        else       r_chain[0] <= i_d;
      end
    end else begin : g_chain
      always_ff @(posedge clk) begin
        if (reset) r_chain <= '0;
        else       r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
      end
    end
  endgenerate

  assign o_q = r_chain[SYNC_STAGES-1];
endmodule
`default_nettype wire

// File: rtl/tempsense_meas_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tempsense_meas_ctrl                                              |
// | Brief   : Sweep/SAR measurement sequencer for the delay-line temperature   |
// |           sensor with optional power-of-two sample averaging.              |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tempsense_meas_ctrl
  import tempsense_pkg::*;
#(
  parameter int N_VDAC      = 6,
  parameter int AVG_LOG2    = 0,
  parameter int PRE_CYCLES  = 1,
  parameter int MEAS_CYCLES = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  tempsense_meas_ctrl_if.master bus
);
  localparam int c_cnt_pm  = (PRE_CYCLES > MEAS_CYCLES) ? PRE_CYCLES : MEAS_CYCLES;
  localparam int c_cnt_max = (c_cnt_pm > SYNC_STAGES) ? c_cnt_pm : SYNC_STAGES;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam int c_acc_w   = N_VDAC + AVG_LOG2;
  localparam int c_samp_w  = AVG_LOG2 + 1;

  localparam logic [c_cnt_w-1:0]  c_pre_last  = c_cnt_w'(PRE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]  c_meas_last = c_cnt_w'(MEAS_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]  c_sync_last = c_cnt_w'(SYNC_STAGES - 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_samp_w-1:0] c_samp_last = c_samp_w'((1 << AVG_LOG2) - 1);
  localparam logic [c_samp_w-1:0] c_samp_one  = c_samp_w'(1);
  localparam logic [N_VDAC-1:0]   c_vmax      = N_VDAC'(vmax(N_VDAC));
  localparam logic [N_VDAC-1:0]   c_vmin      = N_VDAC'(VMIN);
  localparam logic [N_VDAC-1:0]   c_msb       = c_vmax ^ (c_vmax >> 1);
  localparam logic [N_VDAC-1:0]   c_code_one  = N_VDAC'(1);

  state_t               r_state;
  logic                 r_mode;
  logic [N_VDAC-1:0]    r_trial;
  logic [N_VDAC-1:0]    r_keep;
  logic [N_VDAC-1:0]    r_bit;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_samp_w-1:0]  r_samp;
  logic [c_acc_w-1:0]   r_acc;
  logic                 r_sat_lo;
  logic                 r_sat_hi;

  logic                 w_sync;
  logic                 w_pass;
  logic [N_VDAC-1:0]    w_keep_next;
  logic [N_VDAC-1:0]    w_next_trial;
  logic                 w_last_trial;
  logic [c_acc_w-1:0]   w_acc_sum;
  logic                 w_sat_lo;
  logic                 w_sat_hi;

  tempsense_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.i_tempdelay),
    .o_q   (w_sync)
  );

  function automatic logic [N_VDAC-1:0] first_trial(input logic mode);
    return (mode == MODE_SAR) ? c_msb : c_vmin;
  endfunction

  // r_keep holds the best passing code so far in both modes: for an
  // ascending sweep the last pass is the highest, for SAR it is the kept bits.
  always_comb begin
    w_pass      = ~w_sync;
    w_keep_next = w_pass ? r_trial : r_keep;
    if (r_mode == MODE_SAR) begin
      w_last_trial = r_bit[0];
      w_next_trial = w_keep_next | (r_bit >> 1);
    end else begin
      w_last_trial = (r_trial == c_vmax);
      w_next_trial = r_trial + c_code_one;
    end
    w_acc_sum = r_acc + c_acc_w'(r_keep);
    w_sat_lo  = r_sat_lo | (r_keep == c_vmin);
    w_sat_hi  = r_sat_hi | (r_keep == c_vmax);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= ST_IDLE;
      r_mode            <= MODE_SWEEP;
      r_trial           <= '0;
      r_keep            <= '0;
      r_bit             <= '0;
      r_cnt             <= '0;
      r_samp            <= '0;
      r_acc             <= '0;
      r_sat_lo          <= 1'b0;
      r_sat_hi          <= 1'b0;
      bus.o_dac_data    <= c_vmax;
      bus.o_dac_en      <= 1'b0;
      bus.o_precharge_n <= 1'b0;
      bus.o_result      <= '0;
      bus.o_valid       <= 1'b0;
      bus.o_busy        <= 1'b0;
      bus.o_sat_lo      <= 1'b0;
      bus.o_sat_hi      <= 1'b0;
    end else begin
      bus.o_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_mode            <= bus.i_mode;
            r_trial           <= first_trial(bus.i_mode);
            r_bit             <= c_msb;
            r_keep            <= '0;
            r_samp            <= '0;
            r_cnt             <= '0;
            r_state           <= ST_PRECHARGE;
            bus.o_dac_data    <= c_vmax;
            bus.o_dac_en      <= 1'b1;
            bus.o_precharge_n <= 1'b0;
            bus.o_busy        <= 1'b1;
          end
        end
        ST_PRECHARGE: begin
          if (r_cnt == c_pre_last) begin
            r_cnt             <= '0;
            r_state           <= ST_TRANSITION;
            bus.o_dac_data    <= c_vmin;
            bus.o_precharge_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        ST_TRANSITION: begin
          r_cnt          <= '0;
          r_state        <= ST_MEASURE;
          bus.o_dac_data <= r_trial;
        end
        ST_MEASURE: begin
          if (r_cnt == c_meas_last) begin
            r_cnt   <= '0;
            r_state <= ST_EVALUATE;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        ST_EVALUATE: begin
          if (r_cnt == c_sync_last) begin
            r_cnt             <= '0;
            r_keep            <= w_keep_next;
            bus.o_dac_data    <= c_vmax;
            bus.o_precharge_n <= 1'b0;
            if (w_last_trial) begin
              r_state <= ST_ACCUM;
            end else begin
              r_trial <= w_next_trial;
              r_bit   <= r_bit >> 1;
              r_state <= ST_PRECHARGE;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        ST_ACCUM: begin
          r_acc    <= w_acc_sum;
          r_sat_lo <= w_sat_lo;
          r_sat_hi <= w_sat_hi;
          if (r_samp == c_samp_last) begin
            r_state      <= ST_DONE;
            bus.o_result <= N_VDAC'(w_acc_sum >> AVG_LOG2);
            bus.o_valid  <= 1'b1;
            bus.o_sat_lo <= w_sat_lo;
            bus.o_sat_hi <= w_sat_hi;
          end else begin
            r_samp  <= r_samp + c_samp_one;
            r_trial <= first_trial(r_mode);
            r_bit   <= c_msb;
            r_keep  <= '0;
            r_state <= ST_PRECHARGE;
          end
        end
        ST_DONE: begin
          r_acc    <= '0;
          r_sat_lo <= 1'b0;
          r_sat_hi <= 1'b0;
          r_samp   <= '0;
          r_keep   <= '0;
          if (bus.i_continuous) begin
            r_mode  <= bus.i_mode;
            r_trial <= first_trial(bus.i_mode);
            r_bit   <= c_msb;
            r_state <= ST_PRECHARGE;
          end else begin
            r_state      <= ST_IDLE;
            bus.o_dac_en <= 1'b0;
            bus.o_busy   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
